// File: rtl/sdr_audio_pkg.sv
// Shared constants for the audio front end.
// FSM encoding and synchroniser depth.
package sdr_audio_pkg;

  localparam logic [1:0] ST_SEEK  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam int I2S_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// 3-flop synchroniser with one-cycle rise pulse.
// Ports: clk, rst (async, active-low), d_i, rise_o.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  assign sh_d   = {sh_q[1:0], d_i};
  assign rise_o = sh_q[1] & ~sh_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/i2s_audio_rx.sv
// Philips I2S receiver: resyncs to clk, emits one
// stereo pair per frame with a one-cycle stb_out.
// Ports: clk, rst (async, active-low), i2s_bclk,
//   i2s_lrclk, i2s_sdata in; data_out_l/_r,
//   data_out, stb_out, sync_err out.
// Macro I2S_AUDIO_RX_MONO_MIX_EN: data_out = (L+R)/2.
module i2s_audio_rx
  import sdr_audio_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SLOT_MAX = 32,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2s_bclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_sdata,
  output logic [WIDTH-1:0] data_out_l,
  output logic [WIDTH-1:0] data_out_r,
  output logic [WIDTH-1:0] data_out,
  output logic             stb_out,
  output logic             sync_err
);

  localparam logic [CNT_W-1:0] W_C =
    CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] SAT_C =
    CNT_W'(SLOT_MAX + 1);
  localparam int SN = I2S_SYNC_STAGES;

  logic          bit_evt;
  logic [SN-1:0] lr_sync_q;
  logic [SN-1:0] sd_sync_q;
  logic          lr_s;
  logic          sd_s;

  // Sample stage: one clk between the BCLK edge
  // and the FSM so the data sync path lines up.
  logic evt_q;
  logic lr_q;
  logic sd_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             lr_prev_q, lr_prev_d;
  logic [WIDTH-1:0] pend_l_q, pend_l_d;
  logic             have_l_q, have_l_d;
  logic [WIDTH-1:0] l_q, l_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;

  logic             lr_chg;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] sh_nx;
  logic [CNT_W-1:0] pad_w;
  logic [WIDTH-1:0] word;

  sync_edge u_bclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (i2s_bclk),
    .rise_o (bit_evt)
  );

  assign lr_s = lr_sync_q[SN-1];
  assign sd_s = sd_sync_q[SN-1];

  assign lr_chg  = lr_q ^ lr_prev_q;
  assign cnt_inc = (bitcnt_q == SAT_C) ?
                   SAT_C : bitcnt_q + 1'b1;
  // Bits past WIDTH are dropped.
  assign sh_nx   = (bitcnt_q < W_C) ?
                   {shreg_q[WIDTH-2:0], sd_q} :
                   shreg_q;
  // Short slots are left-justified.
  assign pad_w   = W_C - cnt_inc;
  assign word    = (cnt_inc >= W_C) ?
                   sh_nx : (sh_nx << pad_w);

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    lr_prev_d = lr_prev_q;
    pend_l_d  = pend_l_q;
    have_l_d  = have_l_q;
    l_d       = l_q;
    r_d       = r_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    if (evt_q) begin
      lr_prev_d = lr_q;
      bitcnt_d  = cnt_inc;
      shreg_d   = sh_nx;
      if (lr_chg) begin
        // This bit was the LSB of the old slot.
        bitcnt_d = '0;
        shreg_d  = '0;
        unique case (1'b1)
          (state_q == ST_SEEK): begin
            state_d = lr_q ? ST_RIGHT : ST_LEFT;
          end
          (state_q == ST_LEFT): begin
            pend_l_d = word;
            have_l_d = 1'b1;
            state_d  = ST_RIGHT;
          end
          default: begin
            if (have_l_q) begin
              l_d      = pend_l_q;
              r_d      = word;
              stb_d    = 1'b1;
              have_l_d = 1'b0;
            end
            state_d = ST_LEFT;
          end
        endcase
      end else if (cnt_inc == SAT_C &&
                   state_q != ST_SEEK) begin
        err_d    = 1'b1;
        state_d  = ST_SEEK;
        have_l_d = 1'b0;
        bitcnt_d = '0;
        shreg_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_sync_q <= '0;
      sd_sync_q <= '0;
      evt_q     <= 1'b0;
      lr_q      <= 1'b0;
      sd_q      <= 1'b0;
      state_q   <= ST_SEEK;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      lr_prev_q <= 1'b0;
      pend_l_q  <= '0;
      have_l_q  <= 1'b0;
      l_q       <= '0;
      r_q       <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      lr_sync_q <= {lr_sync_q[SN-2:0], i2s_lrclk};
      sd_sync_q <= {sd_sync_q[SN-2:0], i2s_sdata};
      evt_q     <= bit_evt;
      lr_q      <= lr_s;
      sd_q      <= sd_s;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      lr_prev_q <= lr_prev_d;
      pend_l_q  <= pend_l_d;
      have_l_q  <= have_l_d;
      l_q       <= l_d;
      r_q       <= r_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

  assign data_out_l = l_q;
  assign data_out_r = r_q;
  assign stb_out    = stb_q;
  assign sync_err   = err_q;

`ifdef I2S_AUDIO_RX_MONO_MIX_EN
  // One extra bit so the sum cannot overflow;
  // dropping bit 0 is an arithmetic >>> 1.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] mix_q;

  assign sum_w = {pend_l_q[WIDTH-1], pend_l_q} +
                 {word[WIDTH-1], word};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mix_q <= '0;
    end else if (stb_d) begin
      mix_q <= sum_w[WIDTH:1];
    end
  end

  assign data_out = mix_q;
`else
  assign data_out = data_out_l;
`endif

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: directed frames plus random
// slot lengths, checked every cycle against a model.
module tb_i2s_audio_rx;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        bclk = 1'b0;
  logic        lr   = 1'b0;
  logic        sd   = 1'b0;
  logic [15:0] data_out_l;
  logic [15:0] data_out_r;
  logic [15:0] data_out;
  logic        stb_out;
  logic        sync_err;

  i2s_audio_rx #(
    .WIDTH    (16),
    .SLOT_MAX (32),
    .CNT_W    (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i2s_bclk   (bclk),
    .i2s_lrclk  (lr),
    .i2s_sdata  (sd),
    .data_out_l (data_out_l),
    .data_out_r (data_out_r),
    .data_out   (data_out),
    .stb_out    (stb_out),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

`ifdef I2S_AUDIO_RX_MONO_MIX_EN
  localparam logic [15:0] T1_MIX = 16'hFFFF;
`else
  localparam logic [15:0] T1_MIX = 16'h8001;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    bit          stb;
    bit          err;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] m;
  } ev_t;

  ev_t evq[$];
  bit  slot_q[$];
  int  m_mode;     // 0 hunting, 1 in left, 2 in right
  bit  m_prev;
  bit  m_have;
  logic [15:0] m_pend, m_l, m_r, m_m;
  logic [15:0] e_l, e_r, e_m;
  bit  e_stb, e_err;

  function automatic logic [15:0] mixf(
      input logic [15:0] a, input logic [15:0] b);
`ifdef I2S_AUDIO_RX_MONO_MIX_EN
    int s;
    s = int'($signed(a)) + int'($signed(b));
    s = s >>> 1;
    return s[15:0];
`else
    return a + 16'(0 * b);
`endif
  endfunction

  // First 16 bits of the slot, MSB first, zero padded.
  function automatic logic [15:0] slot_word();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w = {w[14:0],
           (i < slot_q.size()) ? slot_q[i] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_reset();
    evq.delete();
    slot_q.delete();
    m_mode = 0; m_prev = 0; m_have = 0;
    m_pend = '0; m_l = '0; m_r = '0; m_m = '0;
    e_l = '0; e_r = '0; e_m = '0;
  endtask

  // Called at the instant BCLK rises; the result is
  // visible four clk edges later.
  task automatic model_rise(input bit l, input bit d);
    bit          chg;
    logic [15:0] w;
    ev_t         ev;
    chg = (l != m_prev);
    m_prev = l;
    if (m_mode == 0) begin
      if (chg) begin
        m_mode = l ? 2 : 1;
        slot_q.delete();
      end
      return;
    end
    slot_q.push_back(d);
    ev = '{cyc: cyc + 4, stb: 0, err: 0,
           l: m_l, r: m_r, m: m_m};
    if (chg) begin
      w = slot_word();
      slot_q.delete();
      if (m_mode == 1) begin
        m_pend = w; m_have = 1; m_mode = 2;
      end else begin
        if (m_have) begin
          m_m = mixf(m_pend, w);
          m_l = m_pend; m_r = w;
          ev.stb = 1; ev.l = m_l;
          ev.r = m_r; ev.m = m_m;
          evq.push_back(ev);
        end
        m_have = 0; m_mode = 1;
      end
    end else if (slot_q.size() == 33) begin
      ev.err = 1;
      evq.push_back(ev);
      m_mode = 0; m_have = 0;
      slot_q.delete();
    end
  endtask

  // ---------------- per-cycle compare ----------------
  ev_t cev;
  always @(negedge clk) begin
    if (chk_en) begin
      e_stb = 0; e_err = 0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        cev = evq.pop_front();
        e_stb |= cev.stb; e_err |= cev.err;
        e_l = cev.l; e_r = cev.r; e_m = cev.m;
      end
      chk("stb_out", 32'(stb_out), 32'(e_stb));
      chk("sync_err", 32'(sync_err), 32'(e_err));
      chk("data_out_l", 32'(data_out_l), 32'(e_l));
      chk("data_out_r", 32'(data_out_r), 32'(e_r));
      chk("data_out", 32'(data_out), 32'(e_m));
      if (stb_out === 1'b1) stb_cnt++;
      if (sync_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  bit pending_lsb = 0;
  bit lead_done   = 0;

  // One BCLK period = 8 clk; data changes on the fall.
  task automatic send_bit(input bit l, input bit d);
    @(negedge clk); #1;
    bclk = 0; lr = l; sd = d;
    repeat (3) @(negedge clk);
    @(negedge clk); #1;
    bclk = 1;
    model_rise(l, d);
    repeat (3) @(negedge clk);
  endtask

  // Slot of n bits; its first BCLK carries the
  // previous slot's LSB.
  task automatic send_slot(input bit l,
                           input logic [31:0] w,
                           input int n);
    if (!lead_done) send_bit(l, pending_lsb);
    lead_done = 0;
    for (int i = 1; i < n; i++) send_bit(l, w[n-i]);
    pending_lsb = w[0];
  endtask

  task automatic send_frame(input logic [31:0] lw,
                            input logic [31:0] rw,
                            input int n);
    send_slot(0, lw, n);
    send_slot(1, rw, n);
  endtask

  // Close the last right slot and let results land.
  task automatic flush();
    send_bit(0, pending_lsb);
    lead_done = 1;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1 bclk = 0;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    model_reset();
    @(negedge clk); #1 rst = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int          s0, e0;
  int          lens[5] = '{8, 12, 16, 20, 32};
  logic [31:0] ra, rb;
  int          n;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1 rst = 1;
    chk_en = 1;
    @(negedge clk); #1;
    chk("init_l", 32'(data_out_l), 32'h0);
    chk("init_stb", 32'(stb_out), 32'h0);

    // 16-bit slots, fixed pattern
    s0 = stb_cnt;
    for (int f = 0; f < 4; f++)
      send_frame(32'h8001, 32'h7FFE, 16);
    flush();
    chk("t1_nstb", 32'(stb_cnt - s0), 32'd3);
    chk("t1_l", 32'(data_out_l), 32'h8001);
    chk("t1_r", 32'(data_out_r), 32'h7FFE);
    chk("t1_mix", 32'(data_out), 32'(T1_MIX));
    chk("t1_model_l", 32'(m_l), 32'h8001);
    chk("t1_model_m", 32'(m_m), 32'(T1_MIX));

    // 32-bit slots: truncation
    rb = $urandom;
    s0 = stb_cnt;
    for (int f = 0; f < 3; f++)
      send_frame(32'h1234ABCD, rb, 32);
    flush();
    chk("t2_nstb", 32'(stb_cnt - s0), 32'd3);
    chk("t2_l", 32'(data_out_l), 32'h1234);
    chk("t2_r", 32'(data_out_r), 32'(rb[31:16]));

    // 8-bit slots: zero padding
    rb = $urandom;
    for (int f = 0; f < 3; f++)
      send_frame(32'hA5, rb, 8);
    flush();
    chk("t3_l", 32'(data_out_l), 32'hA500);
    chk("t3_r", 32'(data_out_r),
        32'({rb[7:0], 8'h00}));
    chk("t3_model_r", 32'(m_r),
        32'({rb[7:0], 8'h00}));

    // LRCLK stuck for 40 BCLKs
    s0 = stb_cnt; e0 = err_cnt;
    for (int i = 0; i < 39; i++)
      send_bit(0, 1'($urandom));
    lead_done = 0;
    chk("t4_nerr", 32'(err_cnt - e0), 32'd1);
    chk("t4_nstb0", 32'(stb_cnt - s0), 32'd0);
    send_slot(1, $urandom, 16);
    ra = $urandom; rb = $urandom;
    send_frame(ra, rb, 16);
    flush();
    chk("t4_nstb1", 32'(stb_cnt - s0), 32'd1);
    chk("t4_l", 32'(data_out_l), 32'(ra[15:0]));

    // reset in the middle of a right slot
    send_slot(0, $urandom, 16);
    send_bit(1, pending_lsb);
    for (int i = 0; i < 7; i++)
      send_bit(1, 1'($urandom));
    do_reset();
    chk("t5_l0", 32'(data_out_l), 32'h0);
    chk("t5_r0", 32'(data_out_r), 32'h0);
    chk("t5_m0", 32'(data_out), 32'h0);
    s0 = stb_cnt;
    lead_done = 0;
    send_slot(1, $urandom, 16);
    ra = $urandom; rb = $urandom;
    send_frame(ra, rb, 16);
    flush();
    chk("t5_nstb", 32'(stb_cnt - s0), 32'd1);
    chk("t5_r", 32'(data_out_r), 32'(rb[15:0]));

    // random slot lengths, occasional stuck LRCLK
    for (int f = 0; f < 24; f++) begin
      n = lens[$urandom_range(4, 0)];
      send_frame($urandom, $urandom, n);
      if ($urandom_range(5, 0) == 0) begin
        for (int i = 0; i < 35; i++)
          send_bit(lr, 1'($urandom));
      end
    end
    flush();

    // mix boundary values
    for (int f = 0; f < 2; f++)
      send_frame(32'h7FFF, 32'h7FFF, 16);
    flush();
    chk("t6_max", 32'(data_out), 32'h7FFF);
    for (int f = 0; f < 2; f++)
      send_frame(32'h8000, 32'h8000, 16);
    flush();
    chk("t6_min", 32'(data_out), 32'h8000);

    repeat (10) @(negedge clk);
    #1;
    chk("evq_drained", 32'(evq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
